// File: rtl/deframer.sv
// deframer: receive-side packet deframer.
//   Accepts packed words from the UART RX path, unpacks each payload word into
//   PackedNum elements (LSB-first), strips the 6-word footer
//   (TailByte0, TailByte1, WH, WL, HH, HL) and publishes the captured image
//   dimensions. On a footer mismatch it hunts for the tail pair to resync.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   valid_i/ready_o/data_i  packed input stream (payload or footer words)
//   valid_o/ready_i         unpacked output handshake
//   unpacked_o              current unpacked element
//   image_width_o           last committed {WH,WL}
//   image_height_o          last committed {HH,HL}
//   frame_done_o            1-cycle pulse when a footer completes
//   sync_err_o              1-cycle pulse on a tail-word mismatch
module deframer #(
    parameter int unsigned UnpackedWidth  = 1,
    parameter int unsigned PackedNum      = 8,
    parameter int unsigned PackedWidth    = UnpackedWidth * PackedNum,
    parameter int unsigned PacketLenElems = 1024,
    parameter logic [PackedWidth-1:0] TailByte0 = 8'hA5,
    parameter logic [PackedWidth-1:0] TailByte1 = 8'h5A,
    localparam int unsigned DimensionWidth = 2 * PackedWidth,
    localparam int unsigned CountWidth     = $clog2(PacketLenElems)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [PackedWidth-1:0]    data_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [UnpackedWidth-1:0]  unpacked_o,
    output logic [DimensionWidth-1:0] image_width_o,
    output logic [DimensionWidth-1:0] image_height_o,
    output logic                      frame_done_o,
    output logic                      sync_err_o
);

    localparam int unsigned ElemCntWidth = $clog2(PackedNum + 1);

    localparam logic [3:0] StPayload = 4'd0;
    localparam logic [3:0] StTail0   = 4'd1;
    localparam logic [3:0] StTail1   = 4'd2;
    localparam logic [3:0] StDimWH   = 4'd3;
    localparam logic [3:0] StDimWL   = 4'd4;
    localparam logic [3:0] StDimHH   = 4'd5;
    localparam logic [3:0] StDimHL   = 4'd6;
    localparam logic [3:0] StHunt0   = 4'd7;
    localparam logic [3:0] StHunt1   = 4'd8;

    logic [3:0]              state_q, state_d;
    logic [CountWidth-1:0]   word_cnt_q;
    logic [PackedWidth-1:0]  shift_q;
    logic [ElemCntWidth-1:0] elems_q;
    logic [PackedWidth-1:0]  wh_q, wl_q, hh_q;
    logic                    in_fire, out_fire, in_payload, last_word, tail_err;

    assign in_payload = (state_q == StPayload);
    assign last_word  = (word_cnt_q == CountWidth'(PacketLenElems - 1));
    assign valid_o    = (elems_q != '0);
    assign unpacked_o = shift_q[UnpackedWidth-1:0];
    assign out_fire   = valid_o && ready_i;

    // A new payload word may replace the buffer when it is empty or when its
    // final element leaves this very cycle; footer words never use the buffer.
    assign ready_o = in_payload
                   ? ((elems_q == '0) || ((elems_q == ElemCntWidth'(1)) && ready_i))
                   : 1'b1;
    assign in_fire = valid_i && ready_o;

    always_comb begin
        state_d  = state_q;
        tail_err = 1'b0;
        if (in_fire) begin
            case (state_q)
                StPayload: if (last_word) state_d = StTail0;
                StTail0: begin
                    if (data_i == TailByte0) begin
                        state_d = StTail1;
                    end else begin
                        state_d  = StHunt0;
                        tail_err = 1'b1;
                    end
                end
                StTail1: begin
                    if (data_i == TailByte1) begin
                        state_d = StDimWH;
                    end else begin
                        state_d  = StHunt0;
                        tail_err = 1'b1;
                    end
                end
                StDimWH: state_d = StDimWL;
                StDimWL: state_d = StDimHH;
                StDimHH: state_d = StDimHL;
                StDimHL: state_d = StPayload;
                StHunt0: if (data_i == TailByte0) state_d = StHunt1;
                StHunt1: begin
                    if (data_i == TailByte1)      state_d = StDimWH;
                    else if (data_i != TailByte0) state_d = StHunt0;
                end
                default: state_d = StPayload;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StPayload;
            word_cnt_q     <= '0;
            shift_q        <= '0;
            elems_q        <= '0;
            wh_q           <= '0;
            wl_q           <= '0;
            hh_q           <= '0;
            image_width_o  <= '0;
            image_height_o <= '0;
            frame_done_o   <= 1'b0;
            sync_err_o     <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_o <= 1'b0;
            sync_err_o   <= tail_err;

            // Load has priority: it only happens when the buffer is empty or
            // its last element is being consumed in the same cycle.
            if (in_fire && in_payload) begin
                shift_q <= data_i;
                elems_q <= ElemCntWidth'(PackedNum);
                if (!last_word) word_cnt_q <= word_cnt_q + CountWidth'(1);
            end else if (out_fire) begin
                shift_q <= shift_q >> UnpackedWidth;
                elems_q <= elems_q - ElemCntWidth'(1);
            end

            if (in_fire) begin
                case (state_q)
                    StDimWH: wh_q <= data_i;
                    StDimWL: wl_q <= data_i;
                    StDimHH: hh_q <= data_i;
                    StDimHL: begin
                        image_width_o  <= {wh_q, wl_q};
                        image_height_o <= {hh_q, data_i};
                        frame_done_o   <= 1'b1;
                        word_cnt_q     <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deframer.sv
// tb_deframer: self-checking bench for deframer.
//   dut_s: UnpackedWidth=2, PackedNum=4, PacketLenElems=4 (directed scenarios).
//   dut_d: default parameters (long random packet).
module tb_deframer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        vi_s = 1'b0, rdy_s = 1'b1, ready_o_s, valid_o_s, fd_s, se_s;
    logic [7:0]  d_s = '0;
    logic [1:0]  unpacked_o_s;
    logic [15:0] width_s, height_s;

    logic        vi_d = 1'b0, rdy_d = 1'b1, ready_o_d, valid_o_d, fd_d, se_d;
    logic [7:0]  d_d = '0;
    logic [0:0]  unpacked_o_d;
    logic [15:0] width_d, height_d;

    deframer #(.UnpackedWidth(2), .PackedNum(4), .PacketLenElems(4)) dut_s (
        .clk_i(clk), .rst_i(rst), .valid_i(vi_s), .ready_o(ready_o_s), .data_i(d_s),
        .valid_o(valid_o_s), .ready_i(rdy_s), .unpacked_o(unpacked_o_s),
        .image_width_o(width_s), .image_height_o(height_s),
        .frame_done_o(fd_s), .sync_err_o(se_s)
    );

    deframer dut_d (
        .clk_i(clk), .rst_i(rst), .valid_i(vi_d), .ready_o(ready_o_d), .data_i(d_d),
        .valid_o(valid_o_d), .ready_i(rdy_d), .unpacked_o(unpacked_o_d),
        .image_width_o(width_d), .image_height_o(height_d),
        .frame_done_o(fd_d), .sync_err_o(se_d)
    );

    int total = 0;
    int bad   = 0;

    int unsigned exp_s[$];
    int unsigned exp_d[$];
    int          rmode = 0;
    bit          pay_s = 1'b0;
    int          fd_cnt_s = 0, se_cnt_s = 0, fd_cnt_d = 0;
    logic [15:0] ew_s = '0, eh_s = '0, ew_d = '0, eh_d = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = toggle each cycle, 2 = random.
    always @(posedge clk) begin
        #1;
        if (rmode == 0)      rdy_s = 1'b1;
        else if (rmode == 1) rdy_s = ~rdy_s;
        else                 rdy_s = 1'($urandom_range(0, 1));
        rdy_d = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Occupancy model for dut_s: elements buffered = 4*words accepted - elements consumed.
    int  words_in_s = 0, elems_out_s = 0, occ;
    bit  held_s = 1'b0;
    logic [1:0] held_val_s;
    always @(negedge clk) begin
        if (rst) begin
            exp_s.delete();
            words_in_s  = 0;
            elems_out_s = 0;
            held_s      = 1'b0;
        end else begin
            occ = words_in_s * 4 - elems_out_s;
            chk("valid_vs_occupancy", {31'd0, valid_o_s}, {31'd0, occ != 0});
            if (vi_s && pay_s) begin
                if (occ > 1)       chk("ready_full", {31'd0, ready_o_s}, 32'd0);
                else if (occ == 1) chk("ready_last", {31'd0, ready_o_s}, {31'd0, rdy_s});
                else               chk("ready_empty", {31'd0, ready_o_s}, 32'd1);
            end
            if (vi_s && !pay_s) chk("ready_footer", {31'd0, ready_o_s}, 32'd1);
            if (held_s) begin
                chk("hold_valid", {31'd0, valid_o_s}, 32'd1);
                chk("hold_data", {30'd0, unpacked_o_s}, {30'd0, held_val_s});
            end
            if (valid_o_s && rdy_s) begin
                total++;
                assert (exp_s.size() != 0) else begin
                    bad++;
                    $error("FAIL elem_s_extra: observed=%0d expected=none", unpacked_o_s);
                end
                if (exp_s.size() != 0) chk("elem_s", {30'd0, unpacked_o_s}, exp_s.pop_front());
                elems_out_s++;
            end
            held_s     = valid_o_s && !rdy_s;
            held_val_s = unpacked_o_s;
            if (vi_s && ready_o_s && pay_s) words_in_s++;
            if (fd_s) fd_cnt_s++;
            if (se_s) se_cnt_s++;
        end
    end

    bit held_d = 1'b0;
    logic held_val_d;
    always @(negedge clk) begin
        if (rst) begin
            exp_d.delete();
            held_d = 1'b0;
        end else begin
            if (held_d) chk("hold_data_d", {31'd0, unpacked_o_d}, {31'd0, held_val_d});
            if (valid_o_d && rdy_d) begin
                total++;
                assert (exp_d.size() != 0) else begin
                    bad++;
                    $error("FAIL elem_d_extra: observed=%0d expected=none", unpacked_o_d);
                end
                if (exp_d.size() != 0) chk("elem_d", {31'd0, unpacked_o_d}, exp_d.pop_front());
            end
            held_d     = valid_o_d && !rdy_d;
            held_val_d = unpacked_o_d[0];
            if (fd_d) fd_cnt_d++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int sel, input logic [7:0] w, input bit pay);
        bit done;
        int unsigned n;
        done = 1'b0;
        n = 0;
        if (sel == 0) begin
            vi_s = 1'b1; d_s = w; pay_s = pay;
        end else begin
            vi_d = 1'b1; d_d = w;
        end
        while (!done) begin
            @(negedge clk);
            done = (sel == 0) ? ready_o_s : ready_o_d;
            tick();
            n++;
            if (!done && n >= 500) begin
                total++;
                bad++;
                $error("FAIL send_timeout: observed=stalled expected=accepted");
                done = 1'b1;
            end
        end
    endtask

    task automatic pay_word(input int sel, input logic [7:0] w);
        if (sel == 0) begin
            for (int k = 0; k < 4; k++) exp_s.push_back((32'(w) >> (2 * k)) & 32'd3);
        end else begin
            for (int k = 0; k < 8; k++) exp_d.push_back((32'(w) >> k) & 32'd1);
        end
        send(sel, w, 1'b1);
    endtask

    task automatic packet(input int sel, input int unsigned nwords, input bit e4,
                          input logic [15:0] w, input logic [15:0] h);
        for (int unsigned i = 0; i < nwords; i++) pay_word(sel, e4 ? 8'hE4 : 8'($urandom));
        send(sel, 8'hA5, 1'b0);
        send(sel, 8'h5A, 1'b0);
        send(sel, w[15:8], 1'b0);
        send(sel, w[7:0], 1'b0);
        send(sel, h[15:8], 1'b0);
        send(sel, h[7:0], 1'b0);
        if (sel == 0) begin ew_s = w; eh_s = h; end
        else          begin ew_d = w; eh_d = h; end
    endtask

    task automatic drain(input int sel);
        int unsigned n;
        n = 0;
        if (sel == 0) begin
            vi_s = 1'b0;
            while ((exp_s.size() != 0 || valid_o_s) && n < 40000) begin tick(); n++; end
            chk("drain_s", exp_s.size(), 0);
        end else begin
            vi_d = 1'b0;
            while ((exp_d.size() != 0 || valid_o_d) && n < 40000) begin tick(); n++; end
            chk("drain_d", exp_d.size(), 0);
        end
        tick();
        tick();
    endtask

    task automatic check_dims_s(input string tag);
        chk({tag, "_width"}, {16'd0, width_s}, {16'd0, ew_s});
        chk({tag, "_height"}, {16'd0, height_s}, {16'd0, eh_s});
    endtask

    logic [15:0] rw, rh;

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'd0, valid_o_s}, 32'd0);
        chk("rst_data", {30'd0, unpacked_o_s}, 32'd0);
        chk("rst_ready", {31'd0, ready_o_s}, 32'd1);
        chk("rst_width", {16'd0, width_s}, 32'd0);
        chk("rst_height", {16'd0, height_s}, 32'd0);
        chk("rst_fd", {31'd0, fd_s}, 32'd0);
        chk("rst_se", {31'd0, se_s}, 32'd0);
        chk("rst_valid_d", {31'd0, valid_o_d}, 32'd0);
        chk("rst_width_d", {16'd0, width_d}, 32'd0);
        tick();

        // Fixed pattern 0xE4 -> elements 0,1,2,3 repeating, ready always high.
        packet(0, 4, 1'b1, 16'h0040, 16'h0030);
        drain(0);
        chk("t1_fd", fd_cnt_s, 1);
        check_dims_s("t1");

        // Same packet with downstream ready toggling every cycle.
        rmode = 1;
        packet(0, 4, 1'b1, 16'h0040, 16'h0030);
        drain(0);
        rmode = 0;
        chk("t2_fd", fd_cnt_s, 2);
        check_dims_s("t2");

        // Bad Tail0, then hunt and resync.
        for (int i = 0; i < 4; i++) pay_word(0, 8'($urandom));
        send(0, 8'h00, 1'b0);
        vi_s = 1'b0;
        tick();
        tick();
        chk("t3_sync_err", se_cnt_s, 1);
        check_dims_s("t3_err");
        send(0, 8'h33, 1'b0);
        send(0, 8'hA5, 1'b0);
        send(0, 8'hA5, 1'b0);
        vi_s = 1'b0;
        tick();
        check_dims_s("t3_hunt");
        send(0, 8'h5A, 1'b0);
        send(0, 8'h01, 1'b0);
        send(0, 8'h00, 1'b0);
        send(0, 8'h00, 1'b0);
        send(0, 8'hF0, 1'b0);
        ew_s = 16'h0100;
        eh_s = 16'h00F0;
        drain(0);
        chk("t3_fd", fd_cnt_s, 3);
        check_dims_s("t3_resync");
        rw = 16'($urandom); rh = 16'($urandom);
        packet(0, 4, 1'b0, rw, rh);
        drain(0);
        chk("t3_payload_fd", fd_cnt_s, 4);
        check_dims_s("t3_payload");

        // Two packets back to back with valid_i held high throughout.
        rmode = 2;
        packet(0, 4, 1'b0, 16'($urandom), 16'($urandom));
        packet(0, 4, 1'b0, 16'($urandom), 16'($urandom));
        drain(0);
        rmode = 0;
        chk("t4_fd", fd_cnt_s, 6);
        chk("t4_se", se_cnt_s, 1);
        check_dims_s("t4");

        // Reset in the middle of a payload.
        pay_word(0, 8'($urandom));
        pay_word(0, 8'($urandom));
        rst  = 1'b1;
        vi_s = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_valid", {31'd0, valid_o_s}, 32'd0);
        chk("t5_rst_width", {16'd0, width_s}, 32'd0);
        tick();
        packet(0, 4, 1'b0, 16'h1234, 16'h0567);
        drain(0);
        chk("t5_fd", fd_cnt_s, 7);
        check_dims_s("t5");

        // Default parameters: full 1024-word random packet, random downstream ready.
        rmode = 2;
        packet(1, 1024, 1'b0, 16'($urandom), 16'($urandom));
        drain(1);
        rmode = 0;
        chk("t6_fd", fd_cnt_d, 1);
        chk("t6_width", {16'd0, width_d}, {16'd0, ew_d});
        chk("t6_height", {16'd0, height_d}, {16'd0, eh_d});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
